mmio_fifo_bridge: RTL and testbench

- Parametrised successor to the single-channel MMIO write/read FIFO shim.
- Bridges the shell's registered MMIO write and read strobes to NUM_CH independent channel pairs.
- Each channel pair has one host-to-user FIFO (H2U) and one user-to-host FIFO (U2H), both internal.
- Adds per-channel status and scratch registers, a sticky overflow flag, and an rready-held read response.
- Sits between the CL MMIO decode and NUM_CH user compute cores.

---
 rtl/mmio_fifo_bridge.sv | 259 +++++++++++++++++++++++++
 tb/tb_mmio_fifo_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_bridge.sv
// MMIO bridge to NUM_CH host-to-user / user-to-host FIFO channel pairs with status, scratch and sticky flags.
// Optional macro MMIO_FIFO_SLVERR_EN: unmapped and empty-DATA reads return rresp = 2'b10.
module mmio_fifo_bridge #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0600
) (
    input  logic                       clk_main_a0,
    input  logic                       rst_main_n_sync,
    input  logic [31:0]                wr_addr,
    input  logic                       wready,
    input  logic [31:0]                wdata,
    input  logic                       arvalid_q,
    input  logic [31:0]                araddr_q,
    input  logic                       rready,
    output logic                       rvalid,
    output logic [31:0]                rdata,
    output logic [1:0]                 rresp,
    output logic [NUM_CH-1:0]          usr_rx_empty,
    input  logic [NUM_CH-1:0]          usr_rx_rd,
    output logic [NUM_CH*DATA_W-1:0]   usr_rx_dout,
    output logic [NUM_CH-1:0]          usr_tx_full,
    input  logic [NUM_CH-1:0]          usr_tx_wr,
    input  logic [NUM_CH*DATA_W-1:0]   usr_tx_din
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [3:0] OFF_DATA    = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_SCRATCH = 4'h8;

`ifdef MMIO_FIFO_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_RESP
    } state_e;

    logic [DATA_W-1:0] h2u_mem_q  [NUM_CH][DEPTH];
    logic [DATA_W-1:0] u2h_mem_q  [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  h2u_wptr_q [NUM_CH];
    logic [PTR_W-1:0]  h2u_rptr_q [NUM_CH];
    logic [PTR_W-1:0]  u2h_wptr_q [NUM_CH];
    logic [PTR_W-1:0]  u2h_rptr_q [NUM_CH];
    logic [CNT_W-1:0]  h2u_cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  u2h_cnt_q  [NUM_CH];
    logic [DATA_W-1:0] h2u_dout_q [NUM_CH];
    logic [DATA_W-1:0] u2h_dout_q [NUM_CH];
    logic [31:0]       scratch_q  [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] unf_q;

    logic [NUM_CH-1:0] h2u_full_c, h2u_empty_c, u2h_full_c, u2h_empty_c;
    logic [NUM_CH-1:0] h2u_push_c, h2u_pop_c, u2h_push_c, u2h_pop_c;
    logic [NUM_CH-1:0] ovf_set_c, ovf_clr_c, unf_clr_c, scratch_we_c;
    logic [NUM_CH-1:0] fsm_pop_c, unf_set_c;

    state_e            state_q, state_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [CH_W-1:0]   rd_ch_q, rd_ch_d;

    // Host write decode
    logic       wr_hit_c;
    logic [3:0] wr_ch_c, wr_off_c;
    assign wr_ch_c  = wr_addr[7:4];
    assign wr_off_c = wr_addr[3:0];
    assign wr_hit_c = wready && (wr_addr[31:8] == BASE_ADDR[31:8]) && ({1'b0, wr_ch_c} < 5'(NUM_CH));

    // Host read decode
    logic            rd_hit_c;
    logic [3:0]      rd_off_c;
    logic [CH_W-1:0] rd_idx_c;
    assign rd_off_c = araddr_q[3:0];
    assign rd_idx_c = araddr_q[4 +: CH_W];
    assign rd_hit_c = (araddr_q[31:8] == BASE_ADDR[31:8]) && ({1'b0, araddr_q[7:4]} < 5'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flags
        assign h2u_full_c[g]  = (h2u_cnt_q[g] == CNT_W'(DEPTH));
        assign h2u_empty_c[g] = (h2u_cnt_q[g] == '0);
        assign u2h_full_c[g]  = (u2h_cnt_q[g] == CNT_W'(DEPTH));
        assign u2h_empty_c[g] = (u2h_cnt_q[g] == '0);
        assign usr_rx_dout[g*DATA_W +: DATA_W] = h2u_dout_q[g];
    end

    assign usr_rx_empty = h2u_empty_c;
    assign usr_tx_full  = u2h_full_c;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign rresp        = rresp_q;

    // Effective push/pop: a simultaneous push lets a pop proceed when empty, and vice versa when full
    always_comb begin
        h2u_push_c   = '0;
        h2u_pop_c    = '0;
        u2h_push_c   = '0;
        u2h_pop_c    = '0;
        ovf_set_c    = '0;
        ovf_clr_c    = '0;
        unf_clr_c    = '0;
        scratch_we_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr_hit_c && (wr_ch_c == 4'(c))) begin
                if (wr_off_c == OFF_DATA) begin
                    h2u_push_c[c] = !h2u_full_c[c] || usr_rx_rd[c];
                    ovf_set_c[c]  = h2u_full_c[c] && !usr_rx_rd[c];
                end
                if (wr_off_c == OFF_STATUS) begin
                    ovf_clr_c[c] = wdata[24];
                    unf_clr_c[c] = wdata[25];
                end
                scratch_we_c[c] = (wr_off_c == OFF_SCRATCH);
            end
            h2u_pop_c[c]  = usr_rx_rd[c] && (!h2u_empty_c[c] || (wr_hit_c && (wr_ch_c == 4'(c)) && (wr_off_c == OFF_DATA)));
            u2h_push_c[c] = usr_tx_wr[c] && (!u2h_full_c[c] || fsm_pop_c[c]);
            u2h_pop_c[c]  = fsm_pop_c[c] && (!u2h_empty_c[c] || usr_tx_wr[c]);
        end
    end

    always_ff @(posedge clk_main_a0) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (h2u_push_c[c]) h2u_mem_q[c][h2u_wptr_q[c]] <= wdata[DATA_W-1:0];
            if (u2h_push_c[c]) u2h_mem_q[c][u2h_wptr_q[c]] <= usr_tx_din[c*DATA_W +: DATA_W];
        end
    end

    // FIFO pointers, counts, head registers, sticky flags and scratch
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                h2u_wptr_q[c] <= '0;
                h2u_rptr_q[c] <= '0;
                u2h_wptr_q[c] <= '0;
                u2h_rptr_q[c] <= '0;
                h2u_cnt_q[c]  <= '0;
                u2h_cnt_q[c]  <= '0;
                h2u_dout_q[c] <= '0;
                u2h_dout_q[c] <= '0;
                scratch_q[c]  <= '0;
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (h2u_push_c[c]) h2u_wptr_q[c] <= h2u_wptr_q[c] + PTR_W'(1);
                if (h2u_pop_c[c]) begin
                    h2u_rptr_q[c] <= h2u_rptr_q[c] + PTR_W'(1);
                    h2u_dout_q[c] <= h2u_empty_c[c] ? wdata[DATA_W-1:0] : h2u_mem_q[c][h2u_rptr_q[c]];
                end
                h2u_cnt_q[c] <= h2u_cnt_q[c] + CNT_W'(h2u_push_c[c]) - CNT_W'(h2u_pop_c[c]);

                if (u2h_push_c[c]) u2h_wptr_q[c] <= u2h_wptr_q[c] + PTR_W'(1);
                if (u2h_pop_c[c]) begin
                    u2h_rptr_q[c] <= u2h_rptr_q[c] + PTR_W'(1);
                    u2h_dout_q[c] <= u2h_empty_c[c] ? usr_tx_din[c*DATA_W +: DATA_W] : u2h_mem_q[c][u2h_rptr_q[c]];
                end
                u2h_cnt_q[c] <= u2h_cnt_q[c] + CNT_W'(u2h_push_c[c]) - CNT_W'(u2h_pop_c[c]);

                if (ovf_set_c[c])      ovf_q[c] <= 1'b1;
                else if (ovf_clr_c[c]) ovf_q[c] <= 1'b0;
                if (unf_set_c[c])      unf_q[c] <= 1'b1;
                else if (unf_clr_c[c]) unf_q[c] <= 1'b0;
                if (scratch_we_c[c])   scratch_q[c] <= wdata;
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rd_ch_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rd_ch_q  <= rd_ch_d;
        end
    end

    // Read FSM: requests are only sampled in IDLE; the response is held until rready
    always_comb begin
        state_d   = state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_ch_d   = rd_ch_q;
        fsm_pop_c = '0;
        unf_set_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (arvalid_q) begin
                    rd_ch_d  = rd_idx_c;
                    rresp_d  = 2'b00;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                    if (!rd_hit_c) begin
                        rdata_d = 32'haaaa_aaaa;
                        rresp_d = ERR_RESP;
                    end else begin
                        case (rd_off_c)
                            OFF_DATA: begin
                                if (!u2h_empty_c[rd_idx_c]) begin
                                    fsm_pop_c[rd_idx_c] = 1'b1;
                                    rvalid_d            = 1'b0;
                                    state_d             = ST_POP;
                                end else begin
                                    rdata_d             = 32'hdead_0000;
                                    rresp_d             = ERR_RESP;
                                    unf_set_c[rd_idx_c] = 1'b1;
                                end
                            end
                            OFF_STATUS: begin
                                rdata_d = {6'd0, unf_q[rd_idx_c], ovf_q[rd_idx_c], 4'd0,
                                           u2h_empty_c[rd_idx_c], u2h_full_c[rd_idx_c],
                                           h2u_empty_c[rd_idx_c], h2u_full_c[rd_idx_c],
                                           7'd0, 9'(u2h_cnt_q[rd_idx_c])};
                            end
                            OFF_SCRATCH: rdata_d = scratch_q[rd_idx_c];
                            default: begin
                                rdata_d = 32'haaaa_aaaa;
                                rresp_d = ERR_RESP;
                            end
                        endcase
                    end
                end
            end
            ST_POP: begin
                rdata_d  = 32'(u2h_dout_q[rd_ch_q]);
                rvalid_d = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// Directed self-checking bench for mmio_fifo_bridge with default parameters.
module tb_mmio_fifo_bridge;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
`ifdef MMIO_FIFO_SLVERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    logic                     clk_main_a0;
    logic                     rst_main_n_sync;
    logic [31:0]              wr_addr;
    logic                     wready;
    logic [31:0]              wdata;
    logic                     arvalid_q;
    logic [31:0]              araddr_q;
    logic                     rready;
    logic                     rvalid;
    logic [31:0]              rdata;
    logic [1:0]               rresp;
    logic [NUM_CH-1:0]        usr_rx_empty;
    logic [NUM_CH-1:0]        usr_rx_rd;
    logic [NUM_CH*DATA_W-1:0] usr_rx_dout;
    logic [NUM_CH-1:0]        usr_tx_full;
    logic [NUM_CH-1:0]        usr_tx_wr;
    logic [NUM_CH*DATA_W-1:0] usr_tx_din;

    int n_cmp = 0;
    int n_err = 0;

    mmio_fifo_bridge #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(32'h0000_0600)
    ) dut (
        .clk_main_a0    (clk_main_a0),
        .rst_main_n_sync(rst_main_n_sync),
        .wr_addr        (wr_addr),
        .wready         (wready),
        .wdata          (wdata),
        .arvalid_q      (arvalid_q),
        .araddr_q       (araddr_q),
        .rready         (rready),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .rresp          (rresp),
        .usr_rx_empty   (usr_rx_empty),
        .usr_rx_rd      (usr_rx_rd),
        .usr_rx_dout    (usr_rx_dout),
        .usr_tx_full    (usr_tx_full),
        .usr_tx_wr      (usr_tx_wr),
        .usr_tx_din     (usr_tx_din)
    );

    initial clk_main_a0 = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        wr_addr = a;
        wdata   = d;
        wready  = 1'b1;
        tick();
        wready  = 1'b0;
    endtask

    // lat = clock edges from the arvalid_q sample edge to the first edge seeing rvalid high
    task automatic host_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
        araddr_q  = a;
        arvalid_q = 1'b1;
        tick();
        arvalid_q = 1'b0;
        lat = 1;
        while (rvalid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        d = rdata;
        r = rresp;
        if (rvalid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL read_timeout addr=%h rvalid=%b want 1", a, rvalid);
        end else begin
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    task automatic pop_rx(input int ch);
        usr_rx_rd[ch] = 1'b1;
        tick();
        usr_rx_rd = '0;
    endtask

    task automatic test_reset();
        rst_main_n_sync = 1'b0;
        repeat (3) tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata); end
        n_cmp++; if (rresp !== 2'b00) begin n_err++; $display("FAIL rst_rresp got %b want 00", rresp); end
        n_cmp++; if (usr_rx_empty !== 4'hF) begin n_err++; $display("FAIL rst_rx_empty got %h want f", usr_rx_empty); end
        n_cmp++; if (usr_tx_full !== 4'h0) begin n_err++; $display("FAIL rst_tx_full got %h want 0", usr_tx_full); end
        n_cmp++; if (usr_rx_dout !== '0) begin n_err++; $display("FAIL rst_rx_dout got %h want 0", usr_rx_dout); end
        rst_main_n_sync = 1'b1;
        tick();
    endtask

    task automatic test_h2u();
        host_write(32'h0000_0610, 32'h1111_0001);
        n_cmp++; if (usr_rx_empty[1] !== 1'b0) begin n_err++; $display("FAIL h2u_not_empty got %b want 0", usr_rx_empty[1]); end
        host_write(32'h0000_0610, 32'h1111_0002);
        host_write(32'h0000_0610, 32'h1111_0003);
        for (int i = 0; i < 3; i++) begin
            pop_rx(1);
            n_cmp++;
            if (usr_rx_dout[63:32] !== 32'h1111_0001 + 32'(i)) begin
                n_err++; $display("FAIL h2u_pop%0d got %h want %h", i, usr_rx_dout[63:32], 32'h1111_0001 + 32'(i));
            end
        end
        n_cmp++; if (usr_rx_empty[1] !== 1'b1) begin n_err++; $display("FAIL h2u_empty_after got %b want 1", usr_rx_empty[1]); end
        pop_rx(1);
        n_cmp++; if (usr_rx_dout[63:32] !== 32'h1111_0003) begin n_err++; $display("FAIL h2u_empty_pop_hold got %h want 11110003", usr_rx_dout[63:32]); end
        // push and pop together on an empty FIFO
        wr_addr = 32'h0000_0610; wdata = 32'h7777_0001; wready = 1'b1; usr_rx_rd[1] = 1'b1;
        tick();
        wready = 1'b0; usr_rx_rd = '0;
        n_cmp++; if (usr_rx_dout[63:32] !== 32'h7777_0001) begin n_err++; $display("FAIL h2u_bypass got %h want 77770001", usr_rx_dout[63:32]); end
        n_cmp++; if (usr_rx_empty[1] !== 1'b1) begin n_err++; $display("FAIL h2u_bypass_empty got %b want 1", usr_rx_empty[1]); end
    endtask

    task automatic test_u2h();
        logic [31:0] d; logic [1:0] r; int lat;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            usr_tx_wr[2] = 1'b1;
            usr_tx_din[2*DATA_W +: DATA_W] = (i == int'(DEPTH)) ? 32'hBAD0_0000 : 32'hCAFE_0000 + 32'(i);
            tick();
        end
        usr_tx_wr = '0;
        n_cmp++; if (usr_tx_full[2] !== 1'b1) begin n_err++; $display("FAIL u2h_full got %b want 1", usr_tx_full[2]); end
        host_read(32'h0000_0624, d, r, lat);
        n_cmp++; if (d !== 32'h0006_0010) begin n_err++; $display("FAIL u2h_status_full got %h want 00060010", d); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL status_latency got %0d want 1", lat); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            host_read(32'h0000_0620, d, r, lat);
            n_cmp++;
            if (d !== 32'hCAFE_0000 + 32'(i) || lat !== 2 || r !== 2'b00) begin
                n_err++; $display("FAIL u2h_read%0d got %h lat %0d resp %b want %h lat 2 resp 00", i, d, lat, r, 32'hCAFE_0000 + 32'(i));
            end
        end
        n_cmp++; if (usr_tx_full[2] !== 1'b0) begin n_err++; $display("FAIL u2h_drained_full got %b want 0", usr_tx_full[2]); end
        host_read(32'h0000_0620, d, r, lat);
        n_cmp++; if (d !== 32'hdead_0000) begin n_err++; $display("FAIL underflow_data got %h want dead0000", d); end
        n_cmp++; if (r !== EXP_ERR) begin n_err++; $display("FAIL underflow_resp got %b want %b", r, EXP_ERR); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL underflow_latency got %0d want 1", lat); end
        host_read(32'h0000_0624, d, r, lat);
        n_cmp++; if (d !== 32'h020A_0000) begin n_err++; $display("FAIL underflow_status got %h want 020a0000", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic [1:0] r; int lat;
        for (int i = 0; i <= int'(DEPTH); i++) host_write(32'h0000_0600, 32'h2000_0000 + 32'(i));
        host_read(32'h0000_0604, d, r, lat);
        n_cmp++; if (d !== 32'h0109_0000) begin n_err++; $display("FAIL ovf_status got %h want 01090000", d); end
        host_write(32'h0000_0604, 32'h0100_0000);
        host_read(32'h0000_0604, d, r, lat);
        n_cmp++; if (d !== 32'h0009_0000) begin n_err++; $display("FAIL ovf_clear got %h want 00090000", d); end
        host_write(32'h0000_0624, 32'h0200_0000);
        host_read(32'h0000_0624, d, r, lat);
        n_cmp++; if (d !== 32'h000A_0000) begin n_err++; $display("FAIL unf_clear got %h want 000a0000", d); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            pop_rx(0);
            n_cmp++;
            if (usr_rx_dout[31:0] !== 32'h2000_0000 + 32'(i)) begin
                n_err++; $display("FAIL ovf_pop%0d got %h want %h", i, usr_rx_dout[31:0], 32'h2000_0000 + 32'(i));
            end
        end
        n_cmp++; if (usr_rx_empty[0] !== 1'b1) begin n_err++; $display("FAIL ovf_dropped got empty %b want 1", usr_rx_empty[0]); end
    endtask

    task automatic test_scratch_unmapped();
        logic [31:0] d; logic [1:0] r; int lat;
        host_write(32'h0000_0628, 32'h5A5A_1234);
        host_write(32'h0000_0638, 32'h1357_9BDF);
        host_write(32'h0000_0728, 32'hFFFF_FFFF);
        host_write(32'h0000_0648, 32'hFFFF_FFFF);
        host_read(32'h0000_0628, d, r, lat);
        n_cmp++; if (d !== 32'h5A5A_1234 || r !== 2'b00) begin n_err++; $display("FAIL scratch got %h resp %b want 5a5a1234 resp 00", d, r); end
        host_read(32'h0000_0640, d, r, lat);
        n_cmp++; if (d !== 32'haaaa_aaaa || r !== EXP_ERR || lat !== 1) begin n_err++; $display("FAIL unmapped_ch got %h resp %b lat %0d want aaaaaaaa resp %b lat 1", d, r, lat, EXP_ERR); end
        host_read(32'h0000_060C, d, r, lat);
        n_cmp++; if (d !== 32'haaaa_aaaa || r !== EXP_ERR) begin n_err++; $display("FAIL unmapped_off got %h resp %b want aaaaaaaa resp %b", d, r, EXP_ERR); end
        host_read(32'h0000_0738, d, r, lat);
        n_cmp++; if (d !== 32'haaaa_aaaa) begin n_err++; $display("FAIL unmapped_base got %h want aaaaaaaa", d); end
    endtask

    task automatic test_rready_hold();
        araddr_q = 32'h0000_0638; arvalid_q = 1'b1;
        tick();
        araddr_q = 32'h0000_0628;
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL hold_start rvalid got %b want 1", rvalid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (rvalid !== 1'b1 || rdata !== 32'h1357_9BDF) begin
                n_err++; $display("FAIL hold%0d rvalid %b rdata %h want 1 13579bdf", i, rvalid, rdata);
            end
        end
        rready = 1'b1; arvalid_q = 1'b0;
        tick();
        rready = 1'b0;
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL hold_release rvalid got %b want 0", rvalid); end
        tick();
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h1357_9BDF) begin n_err++; $display("FAIL hold_ignored rvalid %b rdata %h want 0 13579bdf", rvalid, rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat;
        for (int i = 0; i < 4; i++) begin
            usr_tx_wr[3] = 1'b1;
            usr_tx_din[3*DATA_W +: DATA_W] = 32'h4444_0000 + 32'(i);
            tick();
        end
        usr_tx_wr = '0;
        araddr_q = 32'h0000_0630; arvalid_q = 1'b1;
        tick();
        arvalid_q = 1'b0;
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL pop_state rvalid got %b want 0", rvalid); end
        rst_main_n_sync = 1'b0;
        #2;
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL midrst rvalid %b rdata %h want 0 0", rvalid, rdata); end
        n_cmp++; if (usr_rx_empty !== 4'hF || usr_tx_full !== 4'h0) begin n_err++; $display("FAIL midrst_flags empty %h full %h want f 0", usr_rx_empty, usr_tx_full); end
        tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_hold rvalid got %b want 0", rvalid); end
        rst_main_n_sync = 1'b1;
        tick();
        host_read(32'h0000_0634, d, r, lat);
        n_cmp++; if (d !== 32'h000A_0000 || lat !== 1) begin n_err++; $display("FAIL postrst_status got %h lat %0d want 000a0000 lat 1", d, lat); end
        host_read(32'h0000_0628, d, r, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL postrst_scratch got %h want 0", d); end
        host_read(32'h0000_0604, d, r, lat);
        n_cmp++; if (d !== 32'h000A_0000) begin n_err++; $display("FAIL postrst_ch0 got %h want 000a0000", d); end
        usr_tx_wr[3] = 1'b1;
        usr_tx_din[3*DATA_W +: DATA_W] = 32'h5555_0001;
        tick();
        usr_tx_wr = '0;
        host_read(32'h0000_0630, d, r, lat);
        n_cmp++; if (d !== 32'h5555_0001 || lat !== 2 || r !== 2'b00) begin n_err++; $display("FAIL postrst_read got %h lat %0d resp %b want 55550001 lat 2 resp 00", d, lat, r); end
    endtask

    initial begin
        rst_main_n_sync = 1'b0;
        wr_addr = '0; wready = 1'b0; wdata = '0;
        arvalid_q = 1'b0; araddr_q = '0; rready = 1'b0;
        usr_rx_rd = '0; usr_tx_wr = '0; usr_tx_din = '0;
        test_reset();
        test_h2u();
        test_u2h();
        test_overflow();
        test_scratch_unmapped();
        test_rready_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
